// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
//   Responder for the multiplexed 8-bit address/data RTC bus. Holds a BCD
//   time register file (sec..year) advanced by a clk-derived one-second tick,
//   latches the bus address, accepts writes and drives read data on DatAdd.
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   CS         chip select, active-low
//   AD         0 = address phase, 1 = data phase
//   RD / WR    read / write strobes, active-low
//   DatAdd     multiplexed address/data, driven only while drive_en=1
//   drive_en   responder is driving DatAdd
//   sec_pulse  one-cycle pulse per tick
//
// Optional build macro
//   RTC_SHADOW_EN  write to 0xF0 snapshots the time fields into a shadow bank
//                  that reads of 0x21-0x26 return; without it reads are live.
module rtc_bus_responder #(
   parameter int unsigned CLKS_PER_SEC = 100000000,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       CS,
   input  logic       AD,
   input  logic       RD,
   input  logic       WR,
   inout  wire  [7:0] DatAdd,
   output logic       drive_en,
   output logic       sec_pulse
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_SEC);
   localparam logic [7:0]  A_CTRL = 8'h00;
   localparam logic [7:0]  A_SEC  = 8'h21;
   // Field order: [0]=sec [1]=min [2]=hour [3]=day [4]=month [5]=year.
   // Reset values double as the wrap-to minimum of each field.
   localparam logic [5:0][7:0] TIME_MIN = {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
   // Idle strobe state {CS, AD, RD, WR}.
   localparam logic [3:0] STRB_IDLE = 4'b1011;

   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic                        wr_prev_q;
   logic                        pend_q;
   logic                        pend_ad_q;
   logic [7:0]                  addr_q, addr_d;
   logic [5:0][7:0]             time_q, time_d;
   logic                        halt_q, halt_d;
   logic                        tickf_q, tickf_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        drive_en_q, drive_en_d;
   logic                        sec_pulse_q;
   logic [7:0]                  rdata_q, rdata_d;

   logic                        cs_s, ad_s, rd_s, wr_s;
   logic                        wr_rise_c, read_c, wr_data_c, tick_c;
   logic [7:0]                  wdata_c, dim_c, rd_mux_c;
   logic                        leap_c, carry_c;
   logic [8:0]                  inc_c;
   logic [5:0][7:0]             fmax_c;
   logic [5:0][7:0]             view_c;

   // BCD increment with wrap: returns {carry_out, next_value}.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
      logic [8:0] r;
      if (v >= hi)                r = {1'b1, lo};
      else if (v[3:0] >= 4'd9)    r = {1'b0, v[7:4] + 4'd1, 4'd0};
      else                        r = {1'b0, v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   assign {cs_s, ad_s, rd_s, wr_s} = sync_q[SYNC_STAGES-1];

   // Bus decode on synchronised strobes; RD and WR both low counts as idle.
   assign wr_rise_c = wr_s & ~wr_prev_q & ~cs_s & rd_s;
   assign read_c    = ~cs_s & ad_s & ~rd_s & wr_s;
   assign wr_data_c = pend_q & pend_ad_q;
   assign wdata_c   = DatAdd;
   assign tick_c    = (cnt_q == CNT_W'(CLKS_PER_SEC - 1));

   assign DatAdd    = drive_en_q ? rdata_q : 8'hzz;
   assign drive_en  = drive_en_q;
   assign sec_pulse = sec_pulse_q;

   // Days in month; leap when year%4==0, tested directly on the BCD digits.
   always_comb begin
      leap_c = time_q[5][4] ? (time_q[5][3:0] == 4'd2 || time_q[5][3:0] == 4'd6)
                            : (time_q[5][3:0] == 4'd0 || time_q[5][3:0] == 4'd4 ||
                               time_q[5][3:0] == 4'd8);
      case (time_q[4])
         8'h02:                      dim_c = leap_c ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: dim_c = 8'h30;
         default:                    dim_c = 8'h31;
      endcase
   end

   assign fmax_c = {8'h99, 8'h12, dim_c, 8'h23, 8'h59, 8'h59};

`ifdef RTC_SHADOW_EN
   localparam logic [7:0] A_XFER = 8'hF0;
   logic [5:0][7:0] shadow_q;

   // Snapshot of the live fields taken on any write to the transfer address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                shadow_q <= TIME_MIN;
      else if (wr_data_c && addr_q == A_XFER)    shadow_q <= time_q;
   end

   assign view_c = shadow_q;
`else
   assign view_c = time_q;
`endif

   // Read data selection for the latched address.
   always_comb begin
      rd_mux_c = 8'h00;
      if (addr_q == A_CTRL) rd_mux_c = {6'd0, tickf_q, halt_q};
      for (int i = 0; i < 6; i++) begin
         if (addr_q == A_SEC + 8'(i)) rd_mux_c = view_c[i];
      end
   end

   // Next state: address latch, register writes, tick and BCD carry chain.
   always_comb begin
      addr_d     = addr_q;
      time_d     = time_q;
      halt_d     = halt_q;
      tickf_d    = tickf_q;
      rdata_d    = rdata_q;
      drive_en_d = read_c;
      cnt_d      = tick_c ? '0 : cnt_q + CNT_W'(1);
      carry_c    = tick_c & ~halt_q;
      inc_c      = '0;

      if (pend_q && !pend_ad_q) addr_d = wdata_c;
      if (wr_data_c && addr_q == A_CTRL) halt_d = wdata_c[0];

      // A written field takes the bus value and swallows its carry-out.
      for (int i = 0; i < 6; i++) begin
         inc_c = bcd_inc(time_q[i], TIME_MIN[i], fmax_c[i]);
         if (wr_data_c && addr_q == A_SEC + 8'(i)) begin
            time_d[i] = wdata_c;
            carry_c   = 1'b0;
         end else if (carry_c) begin
            time_d[i] = inc_c[7:0];
            carry_c   = inc_c[8];
         end
      end

      // TICKF clears when a read of ctrl completes; a new tick takes priority.
      if (tick_c)                                         tickf_d = 1'b1;
      else if (drive_en_q && !read_c && addr_q == A_CTRL) tickf_d = 1'b0;

      // Read data is frozen at the start of the read.
      if (read_c && !drive_en_q) rdata_d = rd_mux_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q      <= {SYNC_STAGES{STRB_IDLE}};
         wr_prev_q   <= 1'b1;
         pend_q      <= 1'b0;
         pend_ad_q   <= 1'b0;
         addr_q      <= 8'h00;
         time_q      <= TIME_MIN;
         halt_q      <= 1'b0;
         tickf_q     <= 1'b0;
         cnt_q       <= '0;
         drive_en_q  <= 1'b0;
         sec_pulse_q <= 1'b0;
         rdata_q     <= 8'h00;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], CS, AD, RD, WR};
         wr_prev_q   <= wr_s;
         pend_q      <= wr_rise_c;
         pend_ad_q   <= ad_s;
         addr_q      <= addr_d;
         time_q      <= time_d;
         halt_q      <= halt_d;
         tickf_q     <= tickf_d;
         cnt_q       <= cnt_d;
         drive_en_q  <= drive_en_d;
         sec_pulse_q <= tick_c;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 10-cycle second.
module tb_rtc_bus_responder;

   localparam int unsigned CPS = 10;

   logic       clk;
   logic       tb_reset;
   logic       cs, ad, rd, wr;
   logic       tb_oe;
   logic [7:0] tb_dat;
   wire  [7:0] DatAdd;
   logic       drive_en;
   logic       sec_pulse;

   int total = 0;
   int bad   = 0;

   assign DatAdd = tb_oe ? tb_dat : 8'hzz;

   rtc_bus_responder #(.CLKS_PER_SEC(CPS), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (tb_reset),
      .CS        (cs),
      .AD        (ad),
      .RD        (rd),
      .WR        (wr),
      .DatAdd    (DatAdd),
      .drive_en  (drive_en),
      .sec_pulse (sec_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One write cycle; the value is taken on the 5th rising edge.
   task automatic bus_wr(input logic phase, input logic [7:0] v);
      cs = 1'b0; ad = phase; tb_dat = v; tb_oe = 1'b1; wr = 1'b0;
      @(posedge clk); #1 wr = 1'b1;
      repeat (4) @(posedge clk);
      #1 cs = 1'b1; tb_oe = 1'b0;
   endtask

   // One read cycle, bounded wait for drive_en.
   task automatic bus_rd(output logic [7:0] v, output logic ok);
      ok = 1'b0; v = 8'h00;
      cs = 1'b0; ad = 1'b1; rd = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(posedge clk); #1;
         if (drive_en) begin ok = 1'b1; v = DatAdd; end
      end
      rd = 1'b1;
      repeat (3) @(posedge clk);
      #1 cs = 1'b1;
   endtask

   task automatic write_time(input logic [5:0][7:0] t);
      for (int i = 0; i < 6; i++) begin
         bus_wr(1'b0, 8'h21 + 8'(i));
         bus_wr(1'b1, t[i]);
      end
   endtask

   task automatic read_time(output logic [5:0][7:0] t, output logic ok);
      logic [7:0] v;
      logic       ok1;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus_wr(1'b0, 8'h21 + 8'(i));
         bus_rd(v, ok1);
         t[i] = v;
         ok = ok & ok1;
      end
   endtask

   // Bounded wait for n sec_pulse events; returns just after the last one.
   task automatic wait_pulses(input int n);
      int seen = 0;
      int cyc  = 0;
      while (seen < n && cyc < n * CPS * 2 + 20) begin
         @(posedge clk); #1;
         cyc++;
         if (sec_pulse) seen++;
      end
      total++;
      if (seen != n) begin
         bad++;
         $display("FAIL wait_pulses: got %0d pulses, expected %0d", seen, n);
      end
   endtask

   // Un-halt, let exactly n ticks advance time, halt again.
   task automatic run_ticks(input int n);
      bus_wr(1'b0, 8'h00);
      bus_wr(1'b1, 8'h00);
      wait_pulses(n);
      bus_wr(1'b1, 8'h01);
   endtask

   task automatic halt_clock();
      bus_wr(1'b0, 8'h00);
      bus_wr(1'b1, 8'h01);
   endtask

   task automatic test_reset();
      tb_reset = 1'b0; cs = 1'b1; ad = 1'b0; rd = 1'b1; wr = 1'b1;
      tb_oe = 1'b0; tb_dat = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (drive_en !== 1'b0) begin
         bad++; $display("FAIL reset_drive_en: got %b expected 0", drive_en);
      end
      total++;
      if (sec_pulse !== 1'b0) begin
         bad++; $display("FAIL reset_sec_pulse: got %b expected 0", sec_pulse);
      end
      @(posedge clk); #1 tb_reset = 1'b1;
   endtask

   task automatic test_free_run();
      int         pulses = 0;
      int         wide   = 0;
      logic       prev   = 1'b0;
      logic [7:0] v;
      logic       ok;
      bus_wr(1'b0, 8'h21);
      for (int i = 0; i < 595; i++) begin
         @(posedge clk); #1;
         if (sec_pulse) begin
            pulses++;
            if (prev) wide++;
         end
         prev = sec_pulse;
      end
      total++;
      if (pulses != 60) begin
         bad++; $display("FAIL pulse_count: got %0d expected 60", pulses);
      end
      total++;
      if (wide != 0) begin
         bad++; $display("FAIL pulse_width: %0d multi-cycle pulses, expected 0", wide);
      end
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h00) begin
         bad++; $display("FAIL free_run_sec: got %h ok=%b expected 00", v, ok);
      end
      bus_wr(1'b0, 8'h22);
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h01) begin
         bad++; $display("FAIL free_run_min: got %h ok=%b expected 01", v, ok);
      end
   endtask

   task automatic test_feb_rollover();
      logic [5:0][7:0] t;
      logic            ok;
      halt_clock();
      write_time({8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59});
      run_ticks(1);
      read_time(t, ok);
      total++;
      if (!ok || t !== {8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00}) begin
         bad++; $display("FAIL feb_non_leap: got %h ok=%b expected 230301000000", t, ok);
      end
      write_time({8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59});
      run_ticks(1);
      read_time(t, ok);
      total++;
      if (!ok || t !== {8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00}) begin
         bad++; $display("FAIL feb_leap: got %h ok=%b expected 240229000000", t, ok);
      end
   endtask

   task automatic test_century_wrap();
      logic [5:0][7:0] t;
      logic            ok;
      write_time({8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59});
      run_ticks(1);
      read_time(t, ok);
      total++;
      if (!ok || t !== {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}) begin
         bad++; $display("FAIL century_wrap: got %h ok=%b expected 000101000000", t, ok);
      end
   endtask

   task automatic test_halt_tickf();
      logic [7:0] v;
      logic       ok;
      halt_clock();
      wait_pulses(5);
      bus_wr(1'b0, 8'h21);
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h00) begin
         bad++; $display("FAIL halt_sec: got %h ok=%b expected 00", v, ok);
      end
      bus_wr(1'b0, 8'h00);
      wait_pulses(1);
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h03) begin
         bad++; $display("FAIL ctrl_first_read: got %h ok=%b expected 03", v, ok);
      end
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h01) begin
         bad++; $display("FAIL ctrl_second_read: got %h ok=%b expected 01", v, ok);
      end
      bus_wr(1'b0, 8'h30);
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h00) begin
         bad++; $display("FAIL unmapped_read: got %h ok=%b expected 00", v, ok);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [5:0][7:0] t;
      logic [7:0]      v;
      logic            ok;
      write_time({8'h45, 8'h07, 8'h15, 8'h12, 8'h33, 8'h00});
      cs = 1'b0; ad = 1'b1; rd = 1'b0;
      ok = 1'b0; v = 8'h00;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(posedge clk); #1;
         if (drive_en) begin ok = 1'b1; v = DatAdd; end
      end
      total++;
      if (!ok || v !== 8'h45) begin
         bad++; $display("FAIL pre_reset_read: got %h ok=%b expected 45", v, ok);
      end
      tb_reset = 1'b0;
      #1;
      total++;
      if (drive_en !== 1'b0) begin
         bad++; $display("FAIL reset_release_bus: drive_en=%b expected 0", drive_en);
      end
      rd = 1'b1; cs = 1'b1;
      repeat (2) @(posedge clk);
      #1 tb_reset = 1'b1;
      // Address latch is back at 0, so this reads ctrl before the first tick.
      bus_rd(v, ok);
      total++;
      if (!ok || v !== 8'h00) begin
         bad++; $display("FAIL reset_ctrl: got %h ok=%b expected 00", v, ok);
      end
      // Halt lands one cycle after the first tick: sec has advanced once.
      bus_wr(1'b1, 8'h01);
      read_time(t, ok);
      total++;
      if (!ok || t !== {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01}) begin
         bad++; $display("FAIL reset_time: got %h ok=%b expected 000101000001", t, ok);
      end
   endtask

   task automatic test_shadow();
      logic [7:0] v;
      logic       ok;
      logic [7:0] exp_sec;
`ifdef RTC_SHADOW_EN
      exp_sec = 8'h10;
`else
      exp_sec = 8'h13;
`endif
      bus_wr(1'b0, 8'h21);
      bus_wr(1'b1, 8'h10);
      bus_wr(1'b0, 8'hF0);
      bus_wr(1'b1, 8'h00);
      run_ticks(3);
      bus_wr(1'b0, 8'h21);
      bus_rd(v, ok);
      total++;
      if (!ok || v !== exp_sec) begin
         bad++; $display("FAIL transfer_read: got %h ok=%b expected %h", v, ok, exp_sec);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_feb_rollover();
      test_century_wrap();
      test_halt_tickf();
      test_reset_mid_read();
      test_shadow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Synthesizable responder for the multiplexed 8-bit address/data RTC bus (CS, AD, RD, WR, DatAdd; all strobes active-low) driven by the RTC controller.
- Holds a BCD timekeeping register file (seconds through year) that advances from a clk-derived one-second tick.
- Latches the address, accepts writes and drives read data back onto DatAdd.
- Serves as the on-chip RTC for board builds without the external chip and as the bus-functional responder in controller benches.

Parameters:
CLKS_PER_SEC, 100000000, clk cycles per one-second tick (≥2)
SYNC_STAGES, 2, flip-flop stages synchronising CS/AD/RD/WR (≥2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
CS  input  1  chip select, active-low
AD  input  1  0 = address phase, 1 = data phase
RD  input  1  read strobe, active-low
WR  input  1  write strobe, active-low
DatAdd  inout  8  multiplexed address/data; driven only while drive_en=1, else 8'hZZ
drive_en  output  1  responder is driving DatAdd
sec_pulse  output  1  one-cycle pulse per tick

Behaviour:
- Reset (reset=0, async): sec 00, min 00, hour 00, day 01, month 01, year 00, ctrl 00, addr latch 00, tick counter 0, drive_en 0, sec_pulse 0; DatAdd released immediately, even mid-read.
- Strobes pass SYNC_STAGES flops. Rising/falling edges are detected on the synced versions. DatAdd is sampled one cycle after the synced edge.
- Address phase: synced WR rising with CS=0, AD=0 -> addr latch <= DatAdd.
- Data write: synced WR rising with CS=0, AD=1 -> register[addr] <= DatAdd.
- Read: synced RD low with CS=0, AD=1 -> drive_en=1 on the next cycle, driving register[addr]. It stays 1 until synced RD high or synced CS high; release occurs on that cycle.
- RD and WR both low: treated as idle; no write, no drive.
- Address map:
  - 0x00 ctrl: bit0 HALT (r/w), bit1 TICKF (read-only, set each tick, cleared on completed read of 0x00).
  - 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year (BCD).
  - 0xF0 transfer command.
  - Unmapped reads return 0x00; unmapped writes are ignored.
- Tick: counter 0..CLKS_PER_SEC-1. At terminal count: sec_pulse=1 for one cycle, TICKF set, and time advances unless HALT. The counter keeps running under HALT.
- BCD increment per field:
  - Field ≥ max wraps to min and carries to the next field.
  - Otherwise, units ≥9 -> units 0, tens+1; else units+1.
  - Ranges: sec/min 00-59, hour 00-23, day 01..dim, month 01-12, year 00-99 (year wraps silently).
- dim: 31 for months 01/03/05/07/08/10/12; 30 for 04/06/09/11; 28 for 02, or 29 when year%4==0. Leap test in BCD: tens even and units∈{0,4,8}, or tens odd and units∈{2,6}.
- Write coinciding with a tick: the written field takes the bus value, its carry-out that cycle is suppressed, and lower fields advance normally.
- Non-BCD values are stored as written; the increment rules above apply unchanged.
- Writing 0xF0: no effect unless the optional feature is enabled.

Optional Feature:
- Macro RTC_SHADOW_EN.
- Defined: any write to 0xF0 copies all six time fields into a shadow bank in one cycle. Reads of 0x21-0x26 return the shadow; writes still go to live counters. Shadow resets to reset time values.
- Undefined: no shadow bank; reads return live counters. The 0xF0 write is ignored.

Test Plan:
- CLKS_PER_SEC=10, release reset, wait 600 cycles -> read 0x21=0x00, 0x22=0x01; sec_pulse seen 60 times, each 1 cycle wide.
- Write 0x23=0x23, 0x22=0x59, 0x21=0x59, 0x24=0x28, 0x25=0x02, 0x26=0x23; one tick -> 00:00:00, day 0x01, month 0x03. Repeat with year 0x24 -> day 0x29, month 0x02.
- Set 31-Dec-99 23:59:59, one tick -> all fields reset values (year 0x00).
- Write ctrl=0x01 (HALT), wait 5 ticks -> time unchanged, ctrl read 0x03; second ctrl read 0x01 (TICKF cleared).
- Assert reset low mid-read (drive_en=1) -> drive_en=0 and DatAdd=Z same cycle; all registers at reset values.
- RTC_SHADOW_EN: write 0xF0, wait 3 ticks, read 0x21 -> value at transfer; without macro -> value +3.
